// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN requantisation datapath.
//   CNN_PROD_W : width of the signed product from the 8x8 multiplier stage
//   CNN_OUT_W  : width of the signed activation handed to the next layer
//   CNN_ACC_W  : default accumulator width
//   acc_state_t: handshake state of the product accumulator
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int CNN_PROD_W = 16;
    localparam int CNN_OUT_W  = 8;
    localparam int CNN_ACC_W  = 24;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } acc_state_t;

endpackage : cnn_pkg

// File: rtl/acc_round_sat.sv
// ---------------------------------------------------------------------------
// acc_round_sat
// Purely combinational requantiser: arithmetic right shift with
// round-half-up, then saturation to a signed OUT_W value.
// Optional ReLU on the saturated result when ACC_RELU_EN is defined.
//
// Ports:
//   sum  in  ACC_W  signed accumulator value
//   res  out OUT_W  rounded, shifted, saturated (optionally ReLU'd) value
// ---------------------------------------------------------------------------
module acc_round_sat #(
    parameter int ACC_W = 24,
    parameter int SHIFT = 7,
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] res
);

    // The rounding add is done one bit wider than the accumulator so that
    // the most positive sum plus the half-LSB constant cannot wrap.
    localparam logic signed [ACC_W:0] HALF    = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0]   rounded;
    logic signed [ACC_W:0]   shifted;
    logic        [OUT_W-1:0] sat;

    // Round, shift, clamp into the signed OUT_W range.
    always_comb begin
        rounded = $signed({sum[ACC_W-1], sum}) + HALF;
        shifted = rounded >>> SHIFT;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[OUT_W-1:0];
        end else begin
            sat = shifted[OUT_W-1:0];
        end
    end

    // Fused ReLU clamps negatives to zero; otherwise pass through.
`ifdef ACC_RELU_EN
    always_comb begin
        res = sat[OUT_W-1] ? '0 : sat;
    end
`else
    always_comb begin
        res = sat;
    end
`endif

endmodule : acc_round_sat

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// Sums NUM_TERMS signed products from one multiplier lane, then requantises
// the sum (shift right with round-half-up, saturate to OUT_W) for the next
// layer. Valid/ready handshakes on both sides; one output per window.
// Optional macro: ACC_RELU_EN (fuses a ReLU onto out_data; out_acc is raw).
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous, active-low reset
//   in_valid    in   in_product is valid
//   in_ready    out  a product is accepted this cycle when in_valid is high
//   in_product  in   PROD_W signed product
//   out_valid   out  out_data/out_acc are valid
//   out_ready   in   downstream accepts the output
//   out_data    out  OUT_W rounded, shifted, saturated result
//   out_acc     out  ACC_W raw window sum (debug)
//   busy        out  a window is partially accumulated or an output is pending
// ---------------------------------------------------------------------------
module product_accumulator
    import cnn_pkg::*;
#(
    parameter int PROD_W    = CNN_PROD_W,
    parameter int ACC_W     = CNN_ACC_W,
    parameter int NUM_TERMS = 9,
    parameter int SHIFT     = 7,
    parameter int OUT_W     = CNN_OUT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [ACC_W-1:0]  out_acc,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

    acc_state_t       state_q;
    acc_state_t       state_d;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             last_term;
    logic [OUT_W-1:0] sat_next;

    // The running sum including the product on the input this cycle; the
    // requantiser works on it directly so the result can be registered on
    // the same edge that accepts the final term.
    assign acc_next = acc + {{(ACC_W-PROD_W){in_product[PROD_W-1]}}, in_product};

    acc_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .sum (acc_next),
        .res (sat_next)
    );

    // Next-state and handshake decode. No bypass from OUT back into the
    // input side: in_ready only rises the cycle after the output drains.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        accept    = 1'b0;
        last_term = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready  = 1'b1;
                accept    = in_valid;
                last_term = in_valid && (count == LAST_CNT);
                if (last_term) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator, term counter and the held output pair. out_data/out_acc
    // only change when a window completes, so they stay stable in OUT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            out_data <= '0;
            out_acc  <= '0;
        end else if (accept) begin
            if (last_term) begin
                out_acc  <= acc_next;
                out_data <= sat_next;
                acc      <= '0;
                count    <= '0;
            end else begin
                acc      <= acc_next;
                count    <= count + CNT_W'(1);
            end
        end
    end

    assign out_valid = (state_q == OUT);
    assign busy      = (count != '0) || out_valid;

endmodule : product_accumulator
